ctrl_datapath: RTL and testbench

- Responder to the control FSM's strobes: owns PC, SP, IR (IRU = opcode byte, IRL = operand byte), the accumulator, an 8-bit-wide RAM, the address mux and the write-data mux.
- Returns `opcode`, `NFLAG` and `ZFLAG` to the control FSM.
- Returns memory read data to the external ALU.
- The control FSM updates state on negedge CLK; this block samples every strobe on posedge CLK, so strobes are stable for half a cycle before use.

---
 rtl/ctrl_datapath_if.sv | 40 ++++
 rtl/ctrl_datapath.sv | 108 ++++++++++
 tb/tb_ctrl_datapath.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_datapath_if.sv
// Strobe/status bundle between the control FSM and the datapath.
// The master drives strobes and the ALU result; the slave returns state and memory data.
interface ctrl_datapath_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              LOAD_AC;
    logic              LOAD_IRU;
    logic              LOAD_IRL;
    logic              LOAD_PC;
    logic              INCR_PC;
    logic              FETCH;
    logic              STORE_MEM;
    logic              LOAD_SP;
    logic              DECR_SP;
    logic              INCR_SP;
    logic              FETCH_SP;
    logic              FETCH_DATA;
    logic              FETCH_AC_DATA;
    logic [7:0]        alu_result;

    logic [7:0]        opcode;
    logic              NFLAG;
    logic              ZFLAG;
    logic [7:0]        mem_rdata;
    logic [7:0]        acc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] sp;

    modport master (
        output LOAD_AC, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH, STORE_MEM,
               LOAD_SP, DECR_SP, INCR_SP, FETCH_SP, FETCH_DATA, FETCH_AC_DATA, alu_result,
        input  opcode, NFLAG, ZFLAG, mem_rdata, acc, pc, sp
    );

    modport slave (
        input  LOAD_AC, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH, STORE_MEM,
               LOAD_SP, DECR_SP, INCR_SP, FETCH_SP, FETCH_DATA, FETCH_AC_DATA, alu_result,
        output opcode, NFLAG, ZFLAG, mem_rdata, acc, pc, sp
    );
endinterface

// File: rtl/ctrl_datapath.sv
// Datapath slaved to the control FSM: PC, SP, IR, accumulator and a byte-wide RAM.
// Every strobe is sampled on posedge CLK; the controller changes them on negedge.
module ctrl_datapath #(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DEPTH   = 256,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic           CLK,
    input  logic           RESET,
    ctrl_datapath_if.slave bus
);
    localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] irl_q, irl_d;
    logic [7:0]        iru_q, iru_d;
    logic [7:0]        ac_q, ac_d;

    logic [ADDR_W-1:0] addr;
    logic [IdxW-1:0]   idx;
    logic              in_range;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic [7:0]        ram_q [DEPTH];

    // Stack-relative accesses win; a bare LOAD_IRL is the return-address pop.
    always_comb begin
        addr = irl_q;
        if (bus.FETCH_SP || bus.FETCH_AC_DATA) begin
            addr = sp_q;
        end else if (bus.LOAD_IRL && !bus.FETCH) begin
            addr = sp_q;
        end else if (bus.FETCH) begin
            addr = pc_q;
        end
    end

    assign in_range = {1'b0, addr} < DepthLim;
    assign idx      = addr[IdxW-1:0];
    assign rdata    = in_range ? ram_q[idx] : 8'h00;
    assign wdata    = bus.FETCH_DATA ? 8'(pc_q) : ac_q;

    // RAM contents survive reset; only the write is suppressed while it is held.
    always_ff @(posedge CLK) begin
        if (bus.STORE_MEM && !RESET && in_range) begin
            ram_q[idx] <= wdata;
        end
    end

    always_comb begin
        ac_d  = ac_q;
        iru_d = iru_q;
        irl_d = irl_q;
        pc_d  = pc_q;
        sp_d  = sp_q;

        if (bus.LOAD_AC) begin
            ac_d = bus.FETCH_AC_DATA ? rdata : bus.alu_result;
        end
        if (bus.LOAD_IRU) begin
            iru_d = rdata;
        end
        if (bus.LOAD_IRL) begin
            irl_d = ADDR_W'(rdata);
        end

        if (bus.LOAD_PC) begin
            pc_d = irl_q;
        end else if (bus.INCR_PC) begin
            pc_d = pc_q + 1'b1;
        end

        // Simultaneous push and pop strobes cancel out.
        if (bus.LOAD_SP) begin
            sp_d = irl_q;
        end else if (bus.DECR_SP && !bus.INCR_SP) begin
            sp_d = sp_q - 1'b1;
        end else if (bus.INCR_SP && !bus.DECR_SP) begin
            sp_d = sp_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q  <= '0;
            sp_q  <= SP_INIT;
            irl_q <= '0;
            iru_q <= 8'h00;
            ac_q  <= 8'h00;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            irl_q <= irl_d;
            iru_q <= iru_d;
            ac_q  <= ac_d;
        end
    end

    assign bus.opcode    = iru_q;
    assign bus.NFLAG     = ac_q[7];
    assign bus.ZFLAG     = (ac_q == 8'h00);
    assign bus.mem_rdata = rdata;
    assign bus.acc       = ac_q;
    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
endmodule

// File: tb/tb_ctrl_datapath.sv
// Directed bench for ctrl_datapath: fetch, reset, push/pop, call/return, wrap and flag cases.
module tb_ctrl_datapath;
    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_fail;

    ctrl_datapath_if #(.ADDR_W(8)) bus ();

    ctrl_datapath #(
        .ADDR_W (8),
        .DEPTH  (256),
        .SP_INIT(8'hFF)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic idle();
        bus.LOAD_AC       = 1'b0;
        bus.LOAD_IRU      = 1'b0;
        bus.LOAD_IRL      = 1'b0;
        bus.LOAD_PC       = 1'b0;
        bus.INCR_PC       = 1'b0;
        bus.FETCH         = 1'b0;
        bus.STORE_MEM     = 1'b0;
        bus.LOAD_SP       = 1'b0;
        bus.DECR_SP       = 1'b0;
        bus.INCR_SP       = 1'b0;
        bus.FETCH_SP      = 1'b0;
        bus.FETCH_DATA    = 1'b0;
        bus.FETCH_AC_DATA = 1'b0;
    endtask

    // One clock edge, then release every strobe.
    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic load_ac(input logic [7:0] v);
        bus.alu_result = v;
        bus.LOAD_AC    = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.alu_result = 8'h00;
        idle();
        RESET = 1'b1;
        #12;
        RESET = 1'b0;
        check("rst_pc", bus.pc, 8'h00);
        check("rst_sp", bus.sp, 8'hFF);
        check("rst_acc", bus.acc, 8'h00);
        check("rst_opcode", bus.opcode, 8'h00);
        check("rst_z", bus.ZFLAG, 1'b1);
        check("rst_n", bus.NFLAG, 1'b0);

        // Preload RAM[0]=01 (via IRL=0) and RAM[1]=20 (via PC=1).
        load_ac(8'h01);
        bus.STORE_MEM = 1'b1;
        tick();
        #1 check("init_ram0", bus.mem_rdata, 8'h01);
        bus.alu_result = 8'h20;
        bus.LOAD_AC    = 1'b1;
        bus.INCR_PC    = 1'b1;
        tick();
        bus.FETCH     = 1'b1;
        bus.STORE_MEM = 1'b1;
        tick();
        bus.FETCH = 1'b1;
        #1 check("init_ram1", bus.mem_rdata, 8'h20);
        idle();

        // RAM must survive reset.
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        check("rst2_pc", bus.pc, 8'h00);
        bus.FETCH    = 1'b1;
        bus.INCR_PC  = 1'b1;
        bus.LOAD_IRU = 1'b1;
        tick();
        bus.FETCH    = 1'b1;
        bus.INCR_PC  = 1'b1;
        bus.LOAD_IRL = 1'b1;
        tick();
        check("fetch_opcode", bus.opcode, 8'h01);
        check("fetch_pc", bus.pc, 8'h02);
        bus.LOAD_PC = 1'b1;
        tick();
        check("fetch_irl", bus.pc, 8'h20);

        // Mid-cycle asynchronous reset with PC=5, AC=80.
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        bus.alu_result = 8'h80;
        bus.LOAD_AC    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.INCR_PC = 1'b1;
            tick();
        end
        check("pre_async_pc", bus.pc, 8'h05);
        check("pre_async_n", bus.NFLAG, 1'b1);
        #3;
        RESET = 1'b1;
        #3;
        check("async_pc", bus.pc, 8'h00);
        check("async_acc", bus.acc, 8'h00);
        check("async_z", bus.ZFLAG, 1'b1);
        check("async_n", bus.NFLAG, 1'b0);
        check("async_opcode", bus.opcode, 8'h00);
        RESET = 1'b0;

        // Push 5A, clear AC, pop it back.
        load_ac(8'h5A);
        bus.DECR_SP = 1'b1;
        tick();
        bus.FETCH_SP  = 1'b1;
        bus.STORE_MEM = 1'b1;
        tick();
        check("push_sp", bus.sp, 8'hFE);
        load_ac(8'h00);
        check("push_acc_clr", bus.acc, 8'h00);
        bus.FETCH_SP = 1'b1;
        #1 check("push_ram", bus.mem_rdata, 8'h5A);
        tick();
        bus.FETCH_AC_DATA = 1'b1;
        bus.LOAD_AC       = 1'b1;
        bus.INCR_SP       = 1'b1;
        tick();
        check("pop_acc", bus.acc, 8'h5A);
        check("pop_sp", bus.sp, 8'hFF);

        // Set PC=12 (RAM[0]=12) and IRL=40 (RAM[12]=40).
        load_ac(8'h12);
        bus.STORE_MEM = 1'b1;
        tick();
        bus.FETCH    = 1'b1;
        bus.LOAD_IRL = 1'b1;
        tick();
        bus.LOAD_PC = 1'b1;
        tick();
        check("call_setup_pc", bus.pc, 8'h12);
        load_ac(8'h40);
        bus.STORE_MEM = 1'b1;
        tick();
        bus.FETCH    = 1'b1;
        bus.LOAD_IRL = 1'b1;
        tick();

        // Call: push PC then jump.
        bus.DECR_SP = 1'b1;
        tick();
        bus.FETCH_SP   = 1'b1;
        bus.FETCH_DATA = 1'b1;
        bus.STORE_MEM  = 1'b1;
        tick();
        bus.LOAD_PC = 1'b1;
        tick();
        check("call_pc", bus.pc, 8'h40);
        check("call_sp", bus.sp, 8'hFE);
        bus.FETCH_SP = 1'b1;
        #1 check("call_ram", bus.mem_rdata, 8'h12);
        tick();
        bus.LOAD_IRL = 1'b1;
        bus.INCR_SP  = 1'b1;
        tick();
        bus.LOAD_PC = 1'b1;
        tick();
        check("ret_pc", bus.pc, 8'h12);
        check("ret_sp", bus.sp, 8'hFF);

        // SP wrap both ways and the cancel case.
        bus.INCR_SP = 1'b1;
        tick();
        check("sp_wrap_up", bus.sp, 8'h00);
        bus.DECR_SP = 1'b1;
        tick();
        check("sp_wrap_dn", bus.sp, 8'hFF);
        bus.DECR_SP = 1'b1;
        bus.INCR_SP = 1'b1;
        tick();
        check("sp_both", bus.sp, 8'hFF);

        // PC=FF via RAM[12]=FF, then wrap.
        load_ac(8'hFF);
        bus.STORE_MEM = 1'b1;
        tick();
        bus.FETCH    = 1'b1;
        bus.LOAD_IRL = 1'b1;
        tick();
        bus.LOAD_PC = 1'b1;
        tick();
        check("pc_ff", bus.pc, 8'hFF);
        bus.INCR_PC = 1'b1;
        tick();
        check("pc_wrap", bus.pc, 8'h00);

        // IRL=33 via RAM[FF] read through SP; LOAD_PC beats INCR_PC.
        load_ac(8'h33);
        bus.STORE_MEM = 1'b1;
        tick();
        bus.LOAD_IRL = 1'b1;
        tick();
        bus.LOAD_PC = 1'b1;
        bus.INCR_PC = 1'b1;
        tick();
        check("pc_prio", bus.pc, 8'h33);

        // IRL=10 via RAM[33]; direct store of C3 to RAM[10].
        load_ac(8'h10);
        bus.STORE_MEM = 1'b1;
        tick();
        bus.FETCH    = 1'b1;
        bus.LOAD_IRL = 1'b1;
        tick();
        load_ac(8'hC3);
        bus.STORE_MEM = 1'b1;
        tick();
        #1 check("direct_ram", bus.mem_rdata, 8'hC3);
        load_ac(8'h00);
        check("flag_z", bus.ZFLAG, 1'b1);
        check("flag_z_n", bus.NFLAG, 1'b0);
        load_ac(8'h9F);
        check("flag_n", bus.NFLAG, 1'b1);
        check("flag_n_z", bus.ZFLAG, 1'b0);
        check("flag_acc", bus.acc, 8'h9F);

        // STORE_MEM under reset must leave RAM[0]=12 intact.
        RESET = 1'b1;
        bus.STORE_MEM = 1'b1;
        tick();
        RESET = 1'b0;
        #1 check("rst_store_blocked", bus.mem_rdata, 8'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
